fetch_unit: RTL and testbench

- Sequential fetch/PC-sequencing block for the RISC-V core.
- Sits at the other end of the control decoder's PCSel interface: it consumes PCSel and the ALU-computed target.
- Holds the architectural PC and issues word fetches to instruction memory over a valid/ready request channel.
- Presents one fetched instruction at a time to decode/execute with a valid/ready handshake.
- Single-issue, no speculation: the next fetch starts only after the current instruction is accepted and its PCSel/target are resolved.

---
 rtl/core_pkg.sv | 17 +
 rtl/pc_next_logic.sv | 26 ++
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the core front end.
// Holds the fetch FSM encoding, reset PC default, NOP word and instruction size.
package core_pkg;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_HALT  = 3'd4
   } fetch_state_e;

   localparam logic [31:0] DEF_RESET_PC = 32'h0100_0000;
   localparam logic [31:0] NOP_INST     = 32'h0000_0013;
   localparam int          INST_BYTES   = 4;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC select and taken-target alignment check (combinational).
// Ports: i_pc, i_pcsel, i_target in; o_next_pc, o_misalign out.
module pc_next_logic
   import core_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_pcsel,
   input  logic [XLEN-1:0] i_target,
   output logic [XLEN-1:0] o_next_pc,
   output logic            o_misalign
);

   logic [XLEN-1:0] w_seq_pc;
   logic [XLEN-1:0] w_tgt_pc;

   // Sequential step wraps modulo 2^XLEN.
   assign w_seq_pc = i_pc + XLEN'(INST_BYTES);
   // Bit 0 of a target is dropped, as JALR does.
   assign w_tgt_pc = i_target & ~XLEN'(1);

   assign o_next_pc  = i_pcsel ? w_tgt_pc : w_seq_pc;
   assign o_misalign = i_pcsel & i_target[1];

endmodule

// File: rtl/fetch_unit.sv
// Single-issue fetch sequencer: holds the PC, requests words from imem,
// presents one instruction to execute and steps the PC on accept.
// Ports: clock/reset; PCSel, alu_target from control/ALU; imem_req_* and
// imem_rsp_* to memory; inst_* to execute; misalign_err, retired_count status.
module fetch_unit
   import core_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEF_RESET_PC)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            PCSel,
   input  logic [XLEN-1:0] alu_target,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [XLEN-1:0] inst_pc,
   output logic [XLEN-1:0] inst_data,
   output logic            misalign_err,
   output logic [31:0]     retired_count
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_req_valid;
   logic            r_inst_valid;
   logic [XLEN-1:0] r_inst_pc;
   logic [XLEN-1:0] r_inst_data;
   logic            r_misalign;
   logic [31:0]     r_retired;

   logic [XLEN-1:0] w_next_pc;
   logic            w_misalign;
   logic            w_accept;

   pc_next_logic #(.XLEN(XLEN)) u_pc_next (
      .i_pc       (r_pc),
      .i_pcsel    (PCSel),
      .i_target   (alu_target),
      .o_next_pc  (w_next_pc),
      .o_misalign (w_misalign)
   );

   assign w_accept = r_inst_valid & inst_ready;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_BOOT;
         r_pc         <= RESET_PC;
         r_req_valid  <= 1'b0;
         r_inst_valid <= 1'b0;
         r_inst_pc    <= RESET_PC;
         r_inst_data  <= XLEN'(NOP_INST);
         r_misalign   <= 1'b0;
         r_retired    <= 32'd0;
      end else begin
         unique case (r_state)
            ST_BOOT: begin
               r_state     <= ST_REQ;
               r_req_valid <= 1'b1;
            end
            ST_REQ: begin
               if (imem_req_ready) begin
                  r_state     <= ST_WAIT;
                  r_req_valid <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  r_state      <= ST_ISSUE;
                  r_inst_data  <= imem_rsp_data;
                  r_inst_pc    <= r_pc;
                  r_inst_valid <= 1'b1;
               end
            end
            ST_ISSUE: begin
               // Responses arriving here are stray and never captured.
               if (w_accept) begin
                  r_retired    <= r_retired + 32'd1;
                  r_inst_valid <= 1'b0;
                  if (w_misalign) begin
                     // PC keeps the faulting instruction's address.
                     r_misalign <= 1'b1;
                     r_state    <= ST_HALT;
                  end else begin
                     r_pc        <= w_next_pc;
                     r_req_valid <= 1'b1;
                     r_state     <= ST_REQ;
                  end
               end
            end
            ST_HALT: begin
               r_req_valid  <= 1'b0;
               r_inst_valid <= 1'b0;
            end
            default: begin
               r_state      <= ST_HALT;
               r_req_valid  <= 1'b0;
               r_inst_valid <= 1'b0;
            end
         endcase
      end
   end

   assign imem_req_valid = r_req_valid;
   assign imem_req_addr  = r_pc;
   assign inst_valid     = r_inst_valid;
   assign inst_pc        = r_inst_pc;
   assign inst_data      = r_inst_data;
   assign misalign_err   = r_misalign;
   assign retired_count  = r_retired;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-cycle-latency memory model.
// Each scenario task drives stimulus and checks its own results.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0100_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clock;
   logic        reset;
   logic        PCSel;
   logic [31:0] alu_target;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        misalign_err;
   logic [31:0] retired_count;

   int          total;
   int          bad;
   int          req_cnt;
   logic [31:0] last_addr;
   logic        m_rsp;
   logic [31:0] m_data;
   logic        stray;

   fetch_unit dut (
      .clock          (clock),
      .reset          (reset),
      .PCSel          (PCSel),
      .alu_target     (alu_target),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .misalign_err   (misalign_err),
      .retired_count  (retired_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return ~a;
   endfunction

   // Memory: answers every accepted request on the next cycle.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         m_rsp  <= 1'b0;
         m_data <= 32'h0;
      end else begin
         m_rsp <= imem_req_valid & imem_req_ready;
         if (imem_req_valid & imem_req_ready) begin
            m_data    <= mem_word(imem_req_addr);
            last_addr <= imem_req_addr;
            req_cnt   <= req_cnt + 1;
         end
      end
   end

   assign imem_rsp_valid = m_rsp | stray;
   assign imem_rsp_data  = stray ? 32'hBAD0_BAD0 : m_data;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_inst(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (inst_valid === 1'b1) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic accept(input logic sel, input logic [31:0] tgt);
      PCSel      = sel;
      alu_target = tgt;
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      PCSel      = 1'b0;
   endtask

   task automatic test_reset();
      int cyc;
      repeat (3) step();
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req_valid got=%0b want=0", imem_req_valid); end
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL rst_inst_valid got=%0b want=0", inst_valid); end
      total++; if (inst_data !== NOP) begin bad++; $display("FAIL rst_inst_data got=%h want=%h", inst_data, NOP); end
      total++; if (inst_pc !== RST_PC) begin bad++; $display("FAIL rst_inst_pc got=%h want=%h", inst_pc, RST_PC); end
      total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL rst_count got=%0d want=0", retired_count); end
      total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL rst_misalign got=%0b want=0", misalign_err); end
      reset = 1'b0;
      step();
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL boot_req_valid got=%0b want=1", imem_req_valid); end
      total++; if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL boot_addr got=%h want=%h", imem_req_addr, RST_PC); end
      wait_inst(cyc);
      total++; if (cyc !== 2) begin bad++; $display("FAIL boot_latency got=%0d want=2", cyc); end
      total++; if (inst_pc !== RST_PC) begin bad++; $display("FAIL boot_pc got=%h want=%h", inst_pc, RST_PC); end
      total++; if (inst_data !== mem_word(RST_PC)) begin bad++; $display("FAIL boot_data got=%h want=%h", inst_data, mem_word(RST_PC)); end
      total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL boot_count got=%0d want=0", retired_count); end
   endtask

   task automatic test_sequential();
      int cyc;
      logic [31:0] exp;
      for (int k = 1; k <= 3; k++) begin
         exp = RST_PC + 32'(4 * k);
         accept(1'b0, 32'h0);
         wait_inst(cyc);
         total++; if (cyc !== 2) begin bad++; $display("FAIL seq_latency got=%0d want=2", cyc); end
         total++; if (last_addr !== exp) begin bad++; $display("FAIL seq_addr got=%h want=%h", last_addr, exp); end
         total++; if (inst_pc !== exp) begin bad++; $display("FAIL seq_pc got=%h want=%h", inst_pc, exp); end
         total++; if (inst_data !== mem_word(exp)) begin bad++; $display("FAIL seq_data got=%h want=%h", inst_data, mem_word(exp)); end
      end
      total++; if (retired_count !== 32'd3) begin bad++; $display("FAIL seq_count got=%0d want=3", retired_count); end
   endtask

   task automatic test_jump();
      int cyc;
      accept(1'b1, 32'h0100_0101);
      total++; if (imem_req_addr !== 32'h0100_0100) begin bad++; $display("FAIL jmp_addr got=%h want=01000100", imem_req_addr); end
      wait_inst(cyc);
      total++; if (inst_pc !== 32'h0100_0100) begin bad++; $display("FAIL jmp_pc got=%h want=01000100", inst_pc); end
      total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL jmp_misalign got=%0b want=0", misalign_err); end
      total++; if (retired_count !== 32'd4) begin bad++; $display("FAIL jmp_count got=%0d want=4", retired_count); end
   endtask

   task automatic test_backpressure();
      int cyc;
      int n;
      n = req_cnt;
      repeat (4) begin
         step();
         total++; if (inst_valid !== 1'b1) begin bad++; $display("FAIL bp_inst_valid got=%0b want=1", inst_valid); end
         total++; if (inst_pc !== 32'h0100_0100) begin bad++; $display("FAIL bp_inst_pc got=%h want=01000100", inst_pc); end
         total++; if (inst_data !== mem_word(32'h0100_0100)) begin bad++; $display("FAIL bp_inst_data got=%h want=%h", inst_data, mem_word(32'h0100_0100)); end
         total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL bp_no_req got=%0b want=0", imem_req_valid); end
      end
      total++; if (req_cnt !== n) begin bad++; $display("FAIL bp_req_cnt got=%0d want=%0d", req_cnt, n); end
      imem_req_ready = 1'b0;
      accept(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         stray = (i == 2);
         step();
         stray = 1'b0;
         total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL bp_req_held got=%0b want=1", imem_req_valid); end
         total++; if (imem_req_addr !== 32'h0100_0104) begin bad++; $display("FAIL bp_addr got=%h want=01000104", imem_req_addr); end
         total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL bp_stray got=%0b want=0", inst_valid); end
      end
      imem_req_ready = 1'b1;
      wait_inst(cyc);
      total++; if (cyc !== 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", cyc); end
      total++; if (inst_data !== mem_word(32'h0100_0104)) begin bad++; $display("FAIL bp_data got=%h want=%h", inst_data, mem_word(32'h0100_0104)); end
   endtask

   task automatic test_wrap();
      int cyc;
      stray = 1'b1;
      accept(1'b1, 32'hFFFF_FFFC);
      stray = 1'b0;
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL wrap_drop got=%0b want=0", inst_valid); end
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL wrap_req got=%0b want=1", imem_req_valid); end
      total++; if (imem_req_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h want=fffffffc", imem_req_addr); end
      wait_inst(cyc);
      total++; if (inst_data !== mem_word(32'hFFFF_FFFC)) begin bad++; $display("FAIL wrap_data got=%h want=%h", inst_data, mem_word(32'hFFFF_FFFC)); end
      accept(1'b0, 32'h0);
      total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h want=00000000", imem_req_addr); end
      wait_inst(cyc);
      total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=00000000", inst_pc); end
      total++; if (retired_count !== 32'd7) begin bad++; $display("FAIL wrap_count got=%0d want=7", retired_count); end
   endtask

   task automatic test_misalign();
      int n;
      accept(1'b1, 32'h0100_0102);
      n = req_cnt;
      total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL mis_err got=%0b want=1", misalign_err); end
      total++; if (retired_count !== 32'd8) begin bad++; $display("FAIL mis_count got=%0d want=8", retired_count); end
      total++; if (imem_req_addr !== 32'h0) begin bad++; $display("FAIL mis_pc_kept got=%h want=00000000", imem_req_addr); end
      inst_ready = 1'b1;
      repeat (6) begin
         step();
         total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL halt_req got=%0b want=0", imem_req_valid); end
         total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL halt_inst got=%0b want=0", inst_valid); end
      end
      inst_ready = 1'b0;
      total++; if (req_cnt !== n) begin bad++; $display("FAIL halt_req_cnt got=%0d want=%0d", req_cnt, n); end
      total++; if (misalign_err !== 1'b1) begin bad++; $display("FAIL halt_sticky got=%0b want=1", misalign_err); end
   endtask

   task automatic test_async_reset();
      int cyc;
      #2 reset = 1'b1;
      #1;
      total++; if (misalign_err !== 1'b0) begin bad++; $display("FAIL ar_misalign got=%0b want=0", misalign_err); end
      total++; if (retired_count !== 32'd0) begin bad++; $display("FAIL ar_count got=%0d want=0", retired_count); end
      total++; if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL ar_pc got=%h want=%h", imem_req_addr, RST_PC); end
      step();
      reset = 1'b0;
      imem_req_ready = 1'b0;
      step();
      step();
      total++; if (imem_req_valid !== 1'b1) begin bad++; $display("FAIL ar_req_up got=%0b want=1", imem_req_valid); end
      #2 reset = 1'b1;
      #1;
      total++; if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL ar_req_drop got=%0b want=0", imem_req_valid); end
      step();
      reset = 1'b0;
      imem_req_ready = 1'b1;
      wait_inst(cyc);
      total++; if (cyc !== 3) begin bad++; $display("FAIL ar_reboot got=%0d want=3", cyc); end
      #2 reset = 1'b1;
      #1;
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL ar_inst_drop got=%0b want=0", inst_valid); end
      step();
      reset = 1'b0;
      wait_inst(cyc);
      accept(1'b0, 32'h0);
      step();
      total++; if (imem_req_addr !== RST_PC + 32'd4) begin bad++; $display("FAIL ar_wait_pc got=%h want=%h", imem_req_addr, RST_PC + 32'd4); end
      #2 reset = 1'b1;
      #1;
      total++; if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL ar_pc_back got=%h want=%h", imem_req_addr, RST_PC); end
      step();
      reset = 1'b0;
      step();
      total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL ar_stale got=%0b want=0", inst_valid); end
      total++; if (imem_req_addr !== RST_PC) begin bad++; $display("FAIL ar_refetch got=%h want=%h", imem_req_addr, RST_PC); end
   endtask

   initial begin
      total          = 0;
      bad            = 0;
      req_cnt        = 0;
      last_addr      = 32'h0;
      stray          = 1'b0;
      PCSel          = 1'b0;
      alu_target     = 32'h0;
      imem_req_ready = 1'b1;
      inst_ready     = 1'b0;
      reset          = 1'b0;
      #1 reset       = 1'b1;
      test_reset();
      test_sequential();
      test_jump();
      test_backpressure();
      test_wrap();
      test_misalign();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
